freq_meter: RTL
===============

// Module: freq_meter
// PURPOSE
//  Gated frequency counter. It counts rising edges of an external signal
//  (for example a sensor PWM/DRDY line, or a clk_div output under check)
//  over a fixed window of system-clock cycles. Each window produces a
//  scaled result plus a one-cycle valid strobe.
//  This is the measuring side of our clock-division path: the divider
//  turns 50 MHz into a slow rate, and this block turns a slow rate back
//  into a number. It sits between the sensor pins and the arm-control logic.
// PARAMETERS
//  CLK_FREQ     50_000_000  system clock frequency in Hz; informational only
//  GATE_CYCLES  50_000      window length in clk cycles; must be >= 2
//                           (the default 50_000 cycles is 1 ms)
//  SCALE        1000        result multiplier; freq = edges*SCALE
//                           (with the defaults, the result is in Hz)
//  CW           32          width of the edge counter and of freq
// PORTS
//  clk      in   1   system clock, 50 MHz
//  rst      in   1   asynchronous reset, active-high
//  en       in   1   1 = measure continuously; 0 = abort and go idle
//  sig_in   in   1   asynchronous signal being measured
//  freq     out  CW  last completed result, edges*SCALE, saturated
//  valid    out  1   one-cycle strobe: freq and ovf were just updated
//  ovf      out  1   last result saturated (edge counter or multiply)
//  busy     out  1   1 while a window is in progress
// BEHAVIOUR
//  Reset and clocking
//  - Reset is asynchronous, active-high, on rst; the clock is clk.
//  - Reset values: freq=0, valid=0, ovf=0, busy=0, state=IDLE.
//    Both counters reset to 0.
//  - The synchronizer flops and the edge-history flop reset to 1. A
//    line that is already high at reset release is therefore not
//    counted as an edge.
//  Edge detection
//  - sig_in passes through a 2-flop synchronizer.
//  - edge = s2 & ~s_prev.
//  - sig_in-to-edge latency is 3 clk cycles.
//  - Maximum measurable rate is CLK_FREQ/2, and only when each level is
//    held for at least 1 cycle. Faster inputs alias; this is not flagged.
//  FSM: IDLE, MEASURE
//  - IDLE:
//    - busy=0; edges are ignored; gate_cnt=0 and edge_cnt=0.
//    - en=1 moves to MEASURE on the next cycle.
//  - MEASURE:
//    - busy=1.
//    - Each cycle, gate_cnt increments and edge_cnt += edge.
//    - edge_cnt saturates at 2^CW-1 and sets an internal sat flag.
//  - Last cycle of a window (gate_cnt == GATE_CYCLES-1):
//    - The window closes with the total including that cycle's edge.
//    - freq <= min(total*SCALE, 2^CW-1) (saturating multiply).
//    - ovf <= sat | multiply saturated.
//    - valid=1 on the following cycle, for exactly 1 cycle.
//    - The counters reload: gate_cnt=0, and edge_cnt=0 with sat cleared.
//  - Continuous mode has no dead cycle:
//    - Back-to-back windows are exactly GATE_CYCLES long.
//    - valid strobes every GATE_CYCLES cycles.
//  - en=0 in MEASURE (any cycle, including the last):
//    - The window aborts and the FSM returns to IDLE next cycle.
//    - No valid strobe; freq and ovf hold their previous values.
//    - If en=0 coincides with the last window cycle, abort wins.
//  - rst mid-window: immediate return to the reset values; no valid strobe.
//  - freq and ovf change only on the cycle valid is high. They are stable
//    at all other times, so consumers may sample them at any time.
// STRUCTURE
//  - Shared package freq_meter_pkg holds:
//    - the CLK_FREQ constant (50_000_000), also for the clock divider;
//    - the state encoding (IDLE=1'b0, MEASURE=1'b1);
//    - a clog2 helper used to size gate_cnt.
//  - Sub-module sync_edge_det: 2-flop synchronizer, history flop and
//    rising-edge output, with a reset value parameter (default 1).
//  - The top level holds the FSM, both counters, the saturating
//    multiply and the output registers.
// TESTING
//  Bench parameters: GATE_CYCLES=1000, SCALE=1, CW=32 unless stated.
//  1. en=1, sig_in period 10 cycles (5 high/5 low)
//     -> every window: freq=100, ovf=0, busy=1, one valid per 1000 cycles.
//  2. sig_in held at 1 through reset and beyond
//     -> freq=0 and ovf=0 at every valid.
//  3. en dropped at cycle 500 of a window where the previous freq was 100
//     -> no valid, busy=0 next cycle, freq stays 100.
//  4. CW=8, sig_in toggles every cycle (500 edges)
//     -> freq=255, ovf=1. Next window at period 10 -> freq=100, ovf=0.
//  5. SCALE=1000, CW=16, period 10 (100 edges)
//     -> 100*1000 saturates: freq=65535, ovf=1.
//  6. rst pulsed at cycle 300 of a window
//     -> freq=0, valid=0, ovf=0, busy=0 at once. After release with
//        en=1, the first valid arrives 1001 cycles later.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter and the clock-division path:
// system clock rate, FSM state encoding and a width helper.
package freq_meter_pkg;

    localparam int unsigned CLK_FREQ = 50_000_000;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    // Bits needed to hold values 0..v-1; never less than 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// Two-flop synchronizer plus history flop; flags a rising edge of din.
// All three flops reset to RST_VAL so a line held at that level is not an edge.
module sync_edge_det #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic s1;
    logic s2;
    logic s_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= RST_VAL;
            s2     <= RST_VAL;
            s_prev <= RST_VAL;
        end else begin
            s1     <= din;
            s2     <= s1;
            s_prev <= s2;
        end
    end

    assign rise = s2 & ~s_prev;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over
// GATE_CYCLES clocks and publishes edges*SCALE (saturated) with a valid strobe.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = freq_meter_pkg::CLK_FREQ,
    parameter int unsigned GATE_CYCLES = 50_000,
    parameter int unsigned SCALE       = 1000,
    parameter int unsigned CW          = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          sig_in,
    output logic [CW-1:0] freq,
    output logic          valid,
    output logic          ovf,
    output logic          busy
);

    localparam int unsigned GW = clog2(GATE_CYCLES);
    localparam int unsigned PW = CW + 32;
    localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);

    if (GATE_CYCLES < 2 || CLK_FREQ == 0) begin : g_param_check
        $error("freq_meter: GATE_CYCLES must be >= 2 and CLK_FREQ nonzero");
    end

    state_t        state;
    logic [GW-1:0] gate_cnt;
    logic [CW-1:0] edge_cnt;
    logic          sat;
    logic          rise;

    sync_edge_det #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sig_in),
        .rise (rise)
    );

    // Running total including this cycle's edge, saturating at all-ones.
    logic          cnt_full;
    logic [CW-1:0] total;
    logic          total_sat;
    logic [PW-1:0] prod;
    logic          mul_sat;
    logic [CW-1:0] freq_next;

    always_comb begin
        cnt_full  = &edge_cnt;
        total     = cnt_full ? edge_cnt : edge_cnt + CW'(rise);
        total_sat = sat | (cnt_full & rise);
        prod      = PW'(total) * PW'(SCALE);
        mul_sat   = |prod[PW-1:CW];
        freq_next = mul_sat ? '1 : prod[CW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            freq     <= '0;
            valid    <= 1'b0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    sat      <= 1'b0;
                    if (en) begin
                        state <= MEASURE;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (!en) begin
                        // Abort takes priority even on the closing cycle.
                        state    <= IDLE;
                        busy     <= 1'b0;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                    end else if (gate_cnt == LAST) begin
                        freq     <= freq_next;
                        ovf      <= total_sat | mul_sat;
                        valid    <= 1'b1;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + GW'(1);
                        edge_cnt <= total;
                        sat      <= total_sat;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
